// File: rtl/cmp_search_if.sv
// Comparator-side bundle for the successive-approximation search controller.
// The controller (master) drives the probe and reports status; the comparator
// side (slave) returns the equal/more/less flags and issues start requests.
interface cmp_search_if #(
    parameter int DATALENGTH = 4
);
    logic                  start;
    logic                  equal;
    logic                  more;
    logic                  less;
    logic [DATALENGTH-1:0] probe;
    logic                  busy;
    logic                  done;
    logic                  found;
    logic [DATALENGTH-1:0] result;
    logic [7:0]            steps;

    modport master (
        input  start, equal, more, less,
        output probe, busy, done, found, result, steps
    );

    modport slave (
        output start, equal, more, less,
        input  probe, busy, done, found, result, steps
    );
endinterface

// File: rtl/cmp_search.sv
// Successive-approximation search controller: walks the probe operand of an
// external comparator from MSB to LSB and reports the matched target value.
module cmp_search #(
    parameter int DATALENGTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    cmp_search_if.master  bus
);
    localparam int IW = (DATALENGTH > 1) ? $clog2(DATALENGTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        CHECK  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATALENGTH-1:0] probe_q, probe_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [7:0]            steps_q, steps_d;
    logic [DATALENGTH-1:0] result_q, result_d;
    logic                  found_q, found_d;
    logic                  done_q, done_d;

    logic                  flags_ok;
    logic [7:0]            cnt_inc;

    assign flags_ok = $onehot({bus.equal, bus.more, bus.less});
    assign cnt_inc  = cnt_q + 8'd1;

    // State and datapath registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            probe_q  <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            steps_q  <= '0;
            result_q <= '0;
            found_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            probe_q  <= probe_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            steps_q  <= steps_d;
            result_q <= result_d;
            found_q  <= found_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: one comparator result consumed per clock while busy.
    always_comb begin
        state_d  = state_q;
        probe_d  = probe_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        steps_d  = steps_q;
        result_d = result_q;
        found_d  = found_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    idx_d                = IW'(DATALENGTH - 1);
                    probe_d              = '0;
                    probe_d[DATALENGTH-1] = 1'b1;
                    cnt_d                = '0;
                    found_d              = 1'b0;
                    state_d              = SEARCH;
                end
            end

            SEARCH: begin
                cnt_d = cnt_inc;
                if (!flags_ok) begin
                    // Invalid flag combination: abort with the current probe.
                    result_d = probe_q;
                    found_d  = 1'b0;
                    done_d   = 1'b1;
                    steps_d  = cnt_inc;
                    state_d  = IDLE;
                end else if (bus.equal) begin
                    result_d = probe_q;
                    found_d  = 1'b1;
                    done_d   = 1'b1;
                    steps_d  = cnt_inc;
                    state_d  = IDLE;
                end else begin
                    if (bus.more) begin
                        probe_d[idx_q] = 1'b0;
                    end
                    if (idx_q == '0) begin
                        state_d = CHECK;
                    end else begin
                        idx_d          = idx_q - 1'b1;
                        probe_d[idx_d] = 1'b1;
                    end
                end
            end

            CHECK: begin
                cnt_d    = cnt_inc;
                found_d  = flags_ok && bus.equal;
                result_d = probe_q;
                done_d   = 1'b1;
                steps_d  = cnt_inc;
                state_d  = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.probe  = probe_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
    assign bus.found  = found_q;
    assign bus.result = result_q;
    assign bus.steps  = steps_q;
endmodule

// File: tb/tb_cmp_search.sv
// Self-checking bench for cmp_search: behavioural comparator plus a
// closed-form model of the expected probe sequence and step count.
module tb_cmp_search;
    localparam int DL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   target = 0;
    bit   bad_flags = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    cmp_search_if #(.DATALENGTH(DL)) bus ();

    cmp_search #(.DATALENGTH(DL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Combinational comparator; bad_flags forces an illegal equal+more pair.
    always_comb begin
        bus.equal = (int'(bus.probe) == target) || bad_flags;
        bus.more  = (int'(bus.probe) >  target) || bad_flags;
        bus.less  = (int'(bus.probe) <  target) && !bad_flags;
    end

    // A search ends on the first probe whose remaining low bits are all zero
    // below the set bit, i.e. after DL - (trailing zeros) compares; 0 needs CHECK.
    function automatic int exp_steps(input int t);
        for (int b = 0; b < DL; b++)
            if (t[b]) return DL - b;
        return DL + 1;
    endfunction

    // Probe on compare k: target's top k bits, then a 1 at the next position.
    function automatic int exp_probe(input int t, input int k);
        int hi;
        if (k >= DL) return t;
        hi = (t >> (DL - k)) << (DL - k);
        return hi | (1 << (DL - 1 - k));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Precondition: at a negedge with start=1 and target already set.
    task automatic do_search(input int t, input bit chain);
        int s;
        s = exp_steps(t);
        @(negedge clk);
        for (int k = 0; k < s; k++) begin
            check($sformatf("probe t=%0d k=%0d", t, k), 32'(bus.probe), 32'(exp_probe(t, k)));
            check("busy during search", 32'(bus.busy), 32'd1);
            check("done low during search", 32'(bus.done), 32'd0);
            if (k == 0) check("found cleared on start", 32'(bus.found), 32'd0);
            if (!chain) bus.start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        if (!chain) bus.start = 1'b0;
        check($sformatf("done t=%0d", t), 32'(bus.done), 32'd1);
        check($sformatf("found t=%0d", t), 32'(bus.found), 32'd1);
        check($sformatf("result t=%0d", t), 32'(bus.result), 32'(t));
        check($sformatf("steps t=%0d", t), 32'(bus.steps), 32'(s));
        check("busy low at done", 32'(bus.busy), 32'd0);
        if (!chain) begin
            @(negedge clk);
            check("done single cycle", 32'(bus.done), 32'd0);
            check("idle after done", 32'(bus.busy), 32'd0);
            check("result held", 32'(bus.result), 32'(t));
        end
    endtask

    task automatic single(input int t);
        target    = t;
        bus.start = 1'b1;
        do_search(t, 1'b0);
    endtask

    initial begin
        bus.start = 1'b0;
        #1;
        check("reset probe", 32'(bus.probe), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset found", 32'(bus.found), 32'd0);
        check("reset result", 32'(bus.result), 32'd0);
        check("reset steps", 32'(bus.steps), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle no done", 32'(bus.done), 32'd0);

        // Directed targets from the test plan.
        single(11);
        single(0);
        single(8);
        single(15);

        // Back-to-back sweep with start held high.
        bus.start = 1'b1;
        for (int t = 0; t < (1 << DL); t++) begin
            target = t;
            do_search(t, 1'b1);
        end
        bus.start = 1'b0;
        @(negedge clk);
        check("sweep idle", 32'(bus.busy), 32'd0);
        check("sweep last probe held", 32'(bus.probe), 32'd15);

        // Illegal flags on the second compare abort the search.
        target    = 13;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("abort first probe", 32'(bus.probe), 32'd8);
        @(negedge clk);
        check("abort second probe", 32'(bus.probe), 32'd12);
        bad_flags = 1'b1;
        @(negedge clk);
        bad_flags = 1'b0;
        check("abort done", 32'(bus.done), 32'd1);
        check("abort found", 32'(bus.found), 32'd0);
        check("abort result", 32'(bus.result), 32'd12);
        check("abort busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("abort idle done", 32'(bus.done), 32'd0);
        check("abort idle busy", 32'(bus.busy), 32'd0);

        // Reset during the second compare.
        target    = 5;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("pre-reset probe", 32'(bus.probe), 32'd4);
        #2 rst = 1'b1;
        #1;
        check("mid reset probe", 32'(bus.probe), 32'd0);
        check("mid reset busy", 32'(bus.busy), 32'd0);
        check("mid reset done", 32'(bus.done), 32'd0);
        check("mid reset found", 32'(bus.found), 32'd0);
        check("mid reset result", 32'(bus.result), 32'd0);
        check("mid reset steps", 32'(bus.steps), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post reset no done", 32'(bus.done), 32'd0);
        single(5);

        // Random targets with random start noise while busy.
        for (int i = 0; i < 20; i++) begin
            single(int'($urandom_range(0, (1 << DL) - 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
